fp16_to_int: RTL and testbench
==============================

Name: fp16_to_int

Overview:
- Sequential converter from fp16 (1/5/10, bias 15) to a signed two's-complement integer. Truncates toward zero, like a C cast.
- Sits downstream of fp16add and the other fp16 arithmetic blocks. It decodes their packed fp16 results back into integer form for control and debug datapaths.
- Uses a valid/ready handshake on both sides. The mantissa is aligned one bit per cycle, so the block needs no barrel shifter.

Parameters:
- OUT_W, 16, width of the signed integer result; legal range 12..32.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous and active-high.
- i_valid  input  1  input operand valid.
- o_ready  output  1  block can accept an operand (high only in IDLE).
- i_fp  input  16  fp16 operand; sampled on i_valid && o_ready.
- o_valid  output  1  result valid; held until accepted.
- i_ready  input  1  downstream accepts the result.
- o_int  output  OUT_W  signed integer result.
- o_ovf  output  1  result saturated (out of range, inf, or NaN).
- o_inexact  output  1  nonzero fraction bits were discarded.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - o_valid=0, o_int=0, o_ovf=0, o_inexact=0, o_ready=1 after reset deasserts.
- Fields: s=i_fp[15], e=i_fp[14:10], m=i_fp[9:0]. Unbiased exponent E=e-15, computed signed and 6 bits wide.
- Classification at accept, combinational on i_fp:
  - ZERO: e==0. Subnormals are flushed to zero, matching fp16add. Result 0, ovf=0, inexact=0.
  - SPECIAL: e==31.
    - Inf: saturate by sign to 2^(OUT_W-1)-1 or -2^(OUT_W-1), ovf=1.
    - NaN (m!=0): always 2^(OUT_W-1)-1, ovf=1.
  - SMALL: E<0. Result 0, ovf=0, inexact=1.
  - OVF: E>OUT_W-1, or E==OUT_W-1 unless s==1 && m==0.
    - Saturate by sign, ovf=1, inexact=0.
    - The exception case (s==1, m==0, E==OUT_W-1) is the exact value -2^(OUT_W-1). It goes down the normal path with no ovf.
  - NORMAL: everything else.
    - Load the OUT_W-bit unsigned magnitude register with {1,m}, zero-extended.
    - Load dir=left, cnt=E-10 if E>=10; otherwise dir=right, cnt=10-E.
    - Clear the sticky bit.
- FSM states: IDLE, SHIFT, SIGN, OUT.
  - IDLE: o_ready=1. On i_valid, register the classification result.
    - NORMAL with cnt>0 goes to SHIFT.
    - NORMAL with cnt==0 goes to SIGN.
    - ZERO, SPECIAL, SMALL and OVF go to SIGN with the magnitude/result preloaded. Their saturation constant is final and SIGN passes it through unmodified.
  - SHIFT: each cycle the magnitude shifts one bit in dir and cnt decrements.
    - A right shift ORs the bit shifted out into sticky.
    - Goes to SIGN when cnt reaches 1.
  - SIGN: for NORMAL, o_int = s ? -mag : mag and o_inexact = sticky. Goes to OUT.
  - OUT: o_valid=1. o_int, o_ovf and o_inexact stay stable until i_valid&&... specifically until i_ready is sampled high; then go to IDLE.
- Latency: accept edge to o_valid high is cnt+2 cycles (NORMAL) and 2 cycles for all other classes.
  - Maximum is 12 cycles, at E=0.
  - Throughput is one result per latency+1 cycles; there is no overlap.
- Width rules:
  - The magnitude register is OUT_W bits unsigned. It never overflows on the NORMAL path; the maximum value is 2^(OUT_W-1), in the exact-min case.
  - Negation is OUT_W-bit two's complement.
  - For OUT_W>=17 no finite input overflows, since the fp16 maximum is 65504.
- Boundaries and protocol:
  - i_valid while busy is ignored, with no capture.
  - i_fp may change freely outside the accept cycle.
  - o_ready and o_valid are never high together.
  - Reset during SHIFT or OUT discards the operation; no result is emitted.

Decomposition:
- Shared package fp16_pkg holds:
  - FP16_EXP_W=5, FP16_MANT_W=10, FP16_BIAS=15, FP16_EXP_MAX=31.
  - The class enum (ZERO, SPECIAL, SMALL, OVF, NORMAL).
  - The FSM state encoding.
- One combinational sub-module is natural: fp16_classify. It takes i_fp and OUT_W and returns the class, sign, shift direction and shift count. fp16mul/fp16div will reuse it later.
- The shifter, sticky logic, negation and FSM stay in fp16_to_int.

Test Plan (OUT_W=16):
- Basic values:
  - 0x3C00 (1.0) → o_int=1, ovf=0, inexact=0, o_valid 12 cycles after accept.
  - 0x6400 (1024) → 1024, latency 2.
- Fractions truncate toward zero:
  - 0x3E00 (1.5) → 1, inexact=1.
  - 0xBE00 (-1.5) → 0xFFFF, inexact=1.
  - 0x3800 (0.5) → 0, inexact=1.
  - 0x0200 (subnormal) → 0, inexact=0.
- Range edges:
  - 0xF800 (-32768) → 0x8000, ovf=0.
  - 0x7800 (32768) → 0x7FFF, ovf=1.
  - 0x7BFF (65504) → 0x7FFF, ovf=1.
  - 0x77FF (32752) → 32752, ovf=0, inexact=0.
- Specials:
  - 0x7C00 → 0x7FFF, ovf=1.
  - 0xFC00 → 0x8000, ovf=1.
  - 0xFE00 (NaN) → 0x7FFF, ovf=1.
- Handshake:
  - Hold i_ready=0 for 20 cycles in OUT → o_int/flags stable, o_ready=0, a second i_valid is not captured.
  - Raise i_ready → IDLE next cycle, then accept the next operand.
- Reset and parameter sweep:
  - Assert i_rst mid-SHIFT (0x3C00, cycle 5) → o_valid=0 immediately, no result emitted.
  - After deassert, 0x4500 (5.0) → 5.
  - With OUT_W=32, 0x7BFF → 65504, ovf=0.

Source files
------------

// File: rtl/fp16_pkg.sv
// Purpose: shared fp16 field widths, operand classes and converter FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Ports: none; imported by fp16_classify, fp16_to_int and future fp16 blocks.
package fp16_pkg;

    localparam int FP16_EXP_W   = 5;
    localparam int FP16_MANT_W  = 10;
    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_MAX = 31;

    // Alignment counter width: the count never exceeds 10 (right) or 5 (left).
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SPECIAL,
        CLS_SMALL,
        CLS_OVF,
        CLS_NORMAL
    } fp16_cls_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_SIGN,
        ST_OUT
    } cvt_state_t;

endpackage

// File: rtl/fp16_to_int_if.sv
// Purpose: operand/result handshake bundle between an fp16 producer and fp16_to_int.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and the result side.
// Ports: i_valid/o_ready/i_fp (operand), o_valid/i_ready/o_int/o_ovf/o_inexact (result).
//        Names are from the converter's point of view; the converter uses the slave modport.
interface fp16_to_int_if #(
    parameter int OUT_W = 16
);
    logic             i_valid;
    logic             o_ready;
    logic [15:0]      i_fp;
    logic             o_valid;
    logic             i_ready;
    logic [OUT_W-1:0] o_int;
    logic             o_ovf;
    logic             o_inexact;

    modport master (
        output i_valid, i_fp, i_ready,
        input  o_ready, o_valid, o_int, o_ovf, o_inexact
    );

    modport slave (
        input  i_valid, i_fp, i_ready,
        output o_ready, o_valid, o_int, o_ovf, o_inexact
    );
endinterface

// File: rtl/fp16_classify.sv
// Purpose: combinational fp16 operand classifier and alignment-shift planner.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the outputs are sampled.
// Ports: fp (fp16 operand) -> cls (operand class), sign, shift_left (alignment
//        direction) and shift_cnt (number of one-bit alignment steps, NORMAL only).
module fp16_classify
    import fp16_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic [15:0]      fp,
    output fp16_cls_t        cls,
    output logic             sign,
    output logic             shift_left,
    output logic [CNT_W-1:0] shift_cnt
);

    logic [FP16_EXP_W-1:0]  exp_f;
    logic [FP16_MANT_W-1:0] mant;
    logic signed [5:0]      exp_unb;

    assign sign    = fp[15];
    assign exp_f   = fp[14:10];
    assign mant    = fp[9:0];
    assign exp_unb = $signed({1'b0, exp_f}) - 6'(FP16_BIAS);

    always_comb begin
        // {1,m} carries its binary point 10 bits up, so E-10 is the net shift.
        shift_left = (exp_unb >= 6'sd10);
        shift_cnt  = shift_left ? (exp_unb[3:0] - 4'd10) : (4'd10 - exp_unb[3:0]);

        cls = CLS_NORMAL;
        if (exp_f == '0) begin
            // Subnormals flush to zero, matching the fp16 arithmetic blocks.
            cls = CLS_ZERO;
        end else if (exp_f == FP16_EXP_W'(FP16_EXP_MAX)) begin
            cls = CLS_SPECIAL;
        end else if (exp_unb < 6'sd0) begin
            cls = CLS_SMALL;
        end else if ((int'(exp_unb) > OUT_W - 1) ||
                     ((int'(exp_unb) == OUT_W - 1) && !(sign && (mant == '0)))) begin
            // -2^(OUT_W-1) is the one value with E == OUT_W-1 that fits.
            cls = CLS_OVF;
        end
    end

endmodule

// File: rtl/fp16_to_int.sv
// Purpose: fp16 -> signed OUT_W-bit integer, truncating toward zero, saturating on overflow/inf/NaN.
// Latency: accept edge to o_valid is shift_cnt+2 cycles for NORMAL operands, 2 otherwise (max 12).
// Backpressure: one operand in flight; o_ready only in IDLE, result held in OUT until i_ready.
// Ports: i_clk, i_rst (async, active-high); bus (fp16_to_int_if.slave): i_valid/o_ready/i_fp in,
//        o_valid/i_ready/o_int/o_ovf/o_inexact out.
module fp16_to_int
    import fp16_pkg::*;
#(
    parameter int OUT_W = 16   // legal range 12..32
) (
    input logic          i_clk,
    input logic          i_rst,
    fp16_to_int_if.slave bus
);

    localparam logic [OUT_W-1:0] INT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] INT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    cvt_state_t       state_q, state_d;

    fp16_cls_t        cls;
    logic             fp_sign;
    logic             fp_left;
    logic [CNT_W-1:0] fp_cnt;
    logic             accept;

    logic [OUT_W-1:0] mag_q;      // unsigned magnitude, or the final saturation pattern
    logic [CNT_W-1:0] cnt_q;
    logic             left_q;
    logic             sign_q;
    logic             normal_q;   // only NORMAL results get negated in SIGN
    logic             sticky_q;
    logic             ovf_q;

    fp16_classify #(
        .OUT_W      (OUT_W)
    ) u_classify (
        .fp         (bus.i_fp),
        .cls        (cls),
        .sign       (fp_sign),
        .shift_left (fp_left),
        .shift_cnt  (fp_cnt)
    );

    assign accept      = bus.i_valid && (state_q == ST_IDLE);
    assign bus.o_ready = (state_q == ST_IDLE);
    assign bus.o_valid = (state_q == ST_OUT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ((cls == CLS_NORMAL) && (fp_cnt != '0)) ? ST_SHIFT : ST_SIGN;
                end
            end
            ST_SHIFT: begin
                // The step taken with cnt==1 is the last one.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_SIGN;
                end
            end
            ST_SIGN: state_d = ST_OUT;
            ST_OUT: begin
                if (bus.i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mag_q         <= '0;
            cnt_q         <= '0;
            left_q        <= 1'b0;
            sign_q        <= 1'b0;
            normal_q      <= 1'b0;
            sticky_q      <= 1'b0;
            ovf_q         <= 1'b0;
            bus.o_int     <= '0;
            bus.o_ovf     <= 1'b0;
            bus.o_inexact <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        sign_q   <= fp_sign;
                        left_q   <= fp_left;
                        cnt_q    <= fp_cnt;
                        normal_q <= (cls == CLS_NORMAL);
                        sticky_q <= 1'b0;
                        ovf_q    <= 1'b0;
                        case (cls)
                            CLS_NORMAL: begin
                                mag_q <= {{(OUT_W-FP16_MANT_W-1){1'b0}}, 1'b1,
                                          bus.i_fp[FP16_MANT_W-1:0]};
                            end
                            CLS_SPECIAL: begin
                                // NaN always saturates high; inf follows its sign.
                                mag_q <= (fp_sign && (bus.i_fp[FP16_MANT_W-1:0] == '0)) ?
                                         INT_MIN : INT_MAX;
                                ovf_q <= 1'b1;
                            end
                            CLS_OVF: begin
                                mag_q <= fp_sign ? INT_MIN : INT_MAX;
                                ovf_q <= 1'b1;
                            end
                            CLS_SMALL: begin
                                // Nonzero value below 1: all of it is discarded fraction.
                                mag_q    <= '0;
                                sticky_q <= 1'b1;
                            end
                            default: begin
                                mag_q <= '0;
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (left_q) begin
                        mag_q <= mag_q << 1;
                    end else begin
                        mag_q    <= mag_q >> 1;
                        sticky_q <= sticky_q | mag_q[0];
                    end
                end
                ST_SIGN: begin
                    bus.o_int     <= (normal_q && sign_q) ? (-mag_q) : mag_q;
                    bus.o_ovf     <= ovf_q;
                    bus.o_inexact <= sticky_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_to_int.sv
// Purpose: self-checking bench for fp16_to_int at OUT_W=16 and OUT_W=32 side by side.
// Latency: n/a.
// Backpressure: exercises result stalls, busy-time operand offers and mid-operation reset.
// Ports: none (top-level bench).
module tb_fp16_to_int;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp16_to_int_if #(.OUT_W(16)) b16();
    fp16_to_int_if #(.OUT_W(32)) b32();

    fp16_to_int #(.OUT_W(16)) dut16 (.i_clk(clk), .i_rst(rst), .bus(b16.slave));
    fp16_to_int #(.OUT_W(32)) dut32 (.i_clk(clk), .i_rst(rst), .bus(b32.slave));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] fp;
        logic [15:0] res;
        logic        ovf;
        logic        inex;
        int          lat;
        string       name;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [15:0] fp, input logic [15:0] res, input logic ovf,
                           input logic inex, input int lat, input string name);
        vec_t v;
        v.fp = fp; v.res = res; v.ovf = ovf; v.inex = inex; v.lat = lat; v.name = name;
        vq.push_back(v);
    endtask

    // Reference: evaluate the real value (1.m * 2^(e-15)) with integer arithmetic,
    // truncate toward zero, then clamp to the w-bit signed range.
    task automatic ref_conv(input logic [15:0] fp, input int w, output logic [31:0] val,
                            output logic ovf, output logic inex, output int lat);
        int     e;
        longint sig, v, maxv, minv;
        e    = int'(fp[14:10]);
        sig  = 64'sd1024 + longint'(fp[9:0]);
        maxv = (64'sd1 <<< (w - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (w - 1));
        ovf  = 1'b0;
        inex = 1'b0;
        lat  = 2;
        v    = 0;
        if (e == 0) begin
            v = 0;
        end else if (e == 31) begin
            ovf = 1'b1;
            v   = ((fp[9:0] != 10'd0) || !fp[15]) ? maxv : minv;
        end else begin
            if (e >= 25) begin
                v = sig <<< (e - 25);
            end else begin
                v    = sig >>> (25 - e);
                inex = ((sig & ((64'sd1 <<< (25 - e)) - 64'sd1)) != 0);
            end
            if (fp[15]) v = -v;
            if (v > maxv) begin
                v = maxv; ovf = 1'b1; inex = 1'b0;
            end else if (v < minv) begin
                v = minv; ovf = 1'b1; inex = 1'b0;
            end else if (e >= 15) begin
                // Value >= 1 in range: one cycle per bit of distance from the 2^10 alignment.
                lat = ((e >= 25) ? (e - 25) : (25 - e)) + 2;
            end
        end
        val = v[31:0];
    endtask

    // Offer one operand to both converters with i_ready high and collect both results.
    task automatic run_op(input logic [15:0] fp,
                          output logic [15:0] r16, output logic o16, output logic x16, output int l16,
                          output logic [31:0] r32, output logic o32, output logic x32, output int l32);
        int viol;
        viol = 0;
        r16 = '0; o16 = 1'b0; x16 = 1'b0; l16 = -1;
        r32 = '0; o32 = 1'b0; x32 = 1'b0; l32 = -1;
        @(negedge clk);
        check("ready16 before accept", {31'd0, b16.o_ready}, 32'd1);
        check("ready32 before accept", {31'd0, b32.o_ready}, 32'd1);
        b16.i_valid = 1'b1; b16.i_fp = fp; b16.i_ready = 1'b1;
        b32.i_valid = 1'b1; b32.i_fp = fp; b32.i_ready = 1'b1;
        @(posedge clk); #1;
        b16.i_valid = 1'b0; b16.i_fp = 16'($urandom);
        b32.i_valid = 1'b0; b32.i_fp = 16'($urandom);
        for (int n = 1; n <= 40; n++) begin
            if (b16.o_valid && b16.o_ready) viol++;
            if (b32.o_valid && b32.o_ready) viol++;
            if ((l16 < 0) && b16.o_valid) begin
                l16 = n; r16 = b16.o_int; o16 = b16.o_ovf; x16 = b16.o_inexact;
            end
            if ((l32 < 0) && b32.o_valid) begin
                l32 = n; r32 = b32.o_int; o32 = b32.o_ovf; x32 = b32.o_inexact;
            end
            if ((l16 >= 0) && (l32 >= 0)) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check("ready/valid exclusive", 32'(viol), 32'd0);
    endtask

    task automatic check_model(input logic [15:0] fp, input string tag,
                               input logic [15:0] r16, input logic o16, input logic x16, input int l16,
                               input logic [31:0] r32, input logic o32, input logic x32, input int l32);
        logic [31:0] ev;
        logic        eo, ex;
        int          el;
        ref_conv(fp, 16, ev, eo, ex, el);
        if ({r16, o16, x16} !== {ev[15:0], eo, ex} || l16 != el) begin
            n_checks++; n_fail++;
            $display("FAIL %s w16 fp=%h: got int=%h ovf=%b inx=%b lat=%0d, expected int=%h ovf=%b inx=%b lat=%0d",
                     tag, fp, r16, o16, x16, l16, ev[15:0], eo, ex, el);
        end else n_checks++;
        ref_conv(fp, 32, ev, eo, ex, el);
        if ({r32, o32, x32} !== {ev, eo, ex} || l32 != el) begin
            n_checks++; n_fail++;
            $display("FAIL %s w32 fp=%h: got int=%h ovf=%b inx=%b lat=%0d, expected int=%h ovf=%b inx=%b lat=%0d",
                     tag, fp, r32, o32, x32, l32, ev, eo, ex, el);
        end else n_checks++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r16;
        logic [31:0] r32;
        logic        o16, x16, o32, x32;
        int          l16, l32;
        logic        got, seen;
        int          bad;

        rst = 1'b1;
        b16.i_valid = 1'b0; b16.i_fp = '0; b16.i_ready = 1'b1;
        b32.i_valid = 1'b0; b32.i_fp = '0; b32.i_ready = 1'b1;

        add_vec(16'h3C00, 16'h0001, 1'b0, 1'b0, 12, "1.0");
        add_vec(16'h6400, 16'h0400, 1'b0, 1'b0,  2, "1024");
        add_vec(16'h3E00, 16'h0001, 1'b0, 1'b1, 12, "1.5");
        add_vec(16'hBE00, 16'hFFFF, 1'b0, 1'b1, 12, "-1.5");
        add_vec(16'h3800, 16'h0000, 1'b0, 1'b1,  2, "0.5");
        add_vec(16'h0200, 16'h0000, 1'b0, 1'b0,  2, "subnormal");
        add_vec(16'hF800, 16'h8000, 1'b0, 1'b0,  7, "-32768");
        add_vec(16'h7800, 16'h7FFF, 1'b1, 1'b0,  2, "32768");
        add_vec(16'h7BFF, 16'h7FFF, 1'b1, 1'b0,  2, "65504");
        add_vec(16'h77FF, 16'h7FF0, 1'b0, 1'b0,  6, "32752");
        add_vec(16'h7C00, 16'h7FFF, 1'b1, 1'b0,  2, "+inf");
        add_vec(16'hFC00, 16'h8000, 1'b1, 1'b0,  2, "-inf");
        add_vec(16'hFE00, 16'h7FFF, 1'b1, 1'b0,  2, "NaN");
        add_vec(16'h4500, 16'h0005, 1'b0, 1'b0, 10, "5.0");
        add_vec(16'hC500, 16'hFFFB, 1'b0, 1'b0, 10, "-5.0");

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("valid16 in reset", {31'd0, b16.o_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready16 after reset", {31'd0, b16.o_ready}, 32'd1);
        check("valid16 after reset", {31'd0, b16.o_valid}, 32'd0);
        check("int16 after reset", {16'd0, b16.o_int}, 32'd0);
        check("ovf16 after reset", {31'd0, b16.o_ovf}, 32'd0);
        check("inexact16 after reset", {31'd0, b16.o_inexact}, 32'd0);
        check("ready32 after reset", {31'd0, b32.o_ready}, 32'd1);
        check("int32 after reset", b32.o_int, 32'd0);

        // Directed table (OUT_W=16 expectations hand-derived; OUT_W=32 via the model)
        foreach (vq[i]) begin
            run_op(vq[i].fp, r16, o16, x16, l16, r32, o32, x32, l32);
            check({"int ", vq[i].name}, {16'd0, r16}, {16'd0, vq[i].res});
            check({"ovf ", vq[i].name}, {31'd0, o16}, {31'd0, vq[i].ovf});
            check({"inexact ", vq[i].name}, {31'd0, x16}, {31'd0, vq[i].inex});
            check({"latency ", vq[i].name}, 32'(l16), 32'(vq[i].lat));
            check_model(vq[i].fp, {"table32 ", vq[i].name}, r16, o16, x16, l16, r32, o32, x32, l32);
        end

        // Wide result holds the fp16 maximum exactly
        run_op(16'h7BFF, r16, o16, x16, l16, r32, o32, x32, l32);
        check("w32 65504 int", r32, 32'd65504);
        check("w32 65504 ovf", {31'd0, o32}, 32'd0);
        check("w32 65504 inexact", {31'd0, x32}, 32'd0);

        // Result stall: 20 cycles with i_ready low, plus an operand offered while busy
        @(negedge clk);
        b16.i_valid = 1'b1; b16.i_fp = 16'h3E00; b16.i_ready = 1'b0;
        @(posedge clk); #1;
        b16.i_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(posedge clk); #1;
            if (b16.o_valid) got = 1'b1;
        end
        check("stall reached OUT", {31'd0, got}, 32'd1);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 2) begin b16.i_valid = 1'b1; b16.i_fp = 16'h4500; end
            if (k == 8) b16.i_valid = 1'b0;
            if (b16.o_valid !== 1'b1 || b16.o_ready !== 1'b0) bad++;
            if (b16.o_int !== 16'h0001 || b16.o_ovf !== 1'b0 || b16.o_inexact !== 1'b1) bad++;
        end
        check("stall outputs stable", 32'(bad), 32'd0);
        @(negedge clk);
        b16.i_valid = 1'b0; b16.i_ready = 1'b1;
        @(posedge clk); #1;
        check("release valid", {31'd0, b16.o_valid}, 32'd0);
        check("release ready", {31'd0, b16.o_ready}, 32'd1);
        run_op(16'h4500, r16, o16, x16, l16, r32, o32, x32, l32);
        check("after stall int", {16'd0, r16}, 32'd5);
        check("after stall latency", 32'(l16), 32'd10);

        // Reset in the middle of the alignment shift
        @(negedge clk);
        b16.i_valid = 1'b1; b16.i_fp = 16'h3C00;
        @(posedge clk); #1;
        b16.i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy before reset", {31'd0, b16.o_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("valid at reset", {31'd0, b16.o_valid}, 32'd0);
        check("int cleared by reset", {16'd0, b16.o_int}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (b16.o_valid) seen = 1'b1;
        end
        check("no result after reset", {31'd0, seen}, 32'd0);
        run_op(16'h4500, r16, o16, x16, l16, r32, o32, x32, l32);
        check("post-reset 5.0 int", {16'd0, r16}, 32'd5);
        check("post-reset 5.0 inexact", {31'd0, x16}, 32'd0);

        // Random operands against the arithmetic model, both widths
        for (int i = 0; i < 300; i++) begin
            logic [15:0] fp;
            if (i % 2 == 0) fp = 16'($urandom);
            else fp = {1'($urandom), 5'($urandom_range(31, 10)), 10'($urandom)};
            run_op(fp, r16, o16, x16, l16, r32, o32, x32, l32);
            check_model(fp, "random", r16, o16, x16, l16, r32, o32, x32, l32);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
